// File: rtl/tl45_fetch.sv
// Instruction fetch stage: issues one pipelined Wishbone read at a time and hands
// each returned word to decode through a registered buffer, with a one-entry skid.
module tl45_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic [31:0] i_new_pc,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [29:0] o_wb_addr,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_buf_pc,
    output logic [31:0] o_buf_inst,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_inst_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_inst_q;
    logic [29:0] addr_q;
    logic        cyc_q;
    logic        stb_q;
    logic        err_q;
    logic [31:0] pc_plus4_d;

    assign pc_plus4_d = fetch_pc_q + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            buf_inst_q  <= 32'd0;
            addr_q      <= RESET_PC[31:2];
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (i_pipe_flush) begin
            // Abort any request in flight; a late ack lands in IDLE/ERR and is ignored.
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            buf_inst_q  <= 32'd0;
            fetch_pc_q  <= i_new_pc;
            if (i_new_pc[1:0] != 2'b00) begin
                err_q   <= 1'b1;
                state_q <= S_ERR;
            end else begin
                err_q   <= 1'b0;
                state_q <= S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    addr_q  <= fetch_pc_q[31:2];
                    state_q <= S_BUS;
                    if (!i_pipe_stall) begin
                        buf_pc_q   <= 32'd0;
                        buf_inst_q <= 32'd0;
                    end
                end
                S_BUS: begin
                    if (cyc_q && i_wb_err) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        err_q      <= 1'b1;
                        buf_pc_q   <= 32'd0;
                        buf_inst_q <= 32'd0;
                        state_q    <= S_ERR;
                    end else if (cyc_q && i_wb_ack) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        fetch_pc_q <= pc_plus4_d;
                        if (i_pipe_stall) begin
                            skid_pc_q   <= fetch_pc_q;
                            skid_inst_q <= i_wb_data;
                            state_q     <= S_HOLD;
                        end else begin
                            buf_pc_q   <= fetch_pc_q;
                            buf_inst_q <= i_wb_data;
                            state_q    <= S_IDLE;
                        end
                    end else begin
                        if (stb_q && !i_wb_stall) begin
                            stb_q <= 1'b0;
                        end
                        if (!i_pipe_stall) begin
                            buf_pc_q   <= 32'd0;
                            buf_inst_q <= 32'd0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_pipe_stall) begin
                        buf_pc_q   <= skid_pc_q;
                        buf_inst_q <= skid_inst_q;
                        state_q    <= S_IDLE;
                    end
                end
                S_ERR: begin
                    // Parked until a flush or reset; decode sees bubbles only.
                    buf_pc_q   <= 32'd0;
                    buf_inst_q <= 32'd0;
                    err_q      <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_addr   = addr_q;
    assign o_buf_pc    = buf_pc_q;
    assign o_buf_inst  = buf_inst_q;
    assign o_fetch_err = err_q;

endmodule

// File: tb/tb_tl45_fetch.sv
// Bench for tl45_fetch: directed cycle vectors, multi-cycle corner sequences, and a
// randomized bus/stall run checked against a transaction-level instruction-stream model.
module tb_tl45_fetch;

    logic        clk;
    logic        i_reset;
    logic        i_pipe_stall;
    logic        i_pipe_flush;
    logic [31:0] i_new_pc;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [29:0] o_wb_addr;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_data;
    logic [31:0] o_buf_pc;
    logic [31:0] o_buf_inst;
    logic        o_fetch_err;

    int checks   = 0;
    int failures = 0;

    tl45_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_pipe_stall(i_pipe_stall),
        .i_pipe_flush(i_pipe_flush),
        .i_new_pc    (i_new_pc),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_addr   (o_wb_addr),
        .i_wb_stall  (i_wb_stall),
        .i_wb_ack    (i_wb_ack),
        .i_wb_err    (i_wb_err),
        .i_wb_data   (i_wb_data),
        .o_buf_pc    (o_buf_pc),
        .o_buf_inst  (o_buf_inst),
        .o_fetch_err (o_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pst;
        logic        fl;
        logic [31:0] npc;
        logic        wst;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        cyc;
        logic        stb;
        logic [29:0] addr;
        logic [31:0] bpc;
        logic [31:0] binst;
        logic        ferr;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    function automatic vec_t mkv(
        input logic rst, input logic pst, input logic fl, input logic [31:0] npc,
        input logic wst, input logic ack, input logic err, input logic [31:0] dat,
        input logic cyc, input logic stb, input logic [29:0] addr,
        input logic [31:0] bpc, input logic [31:0] binst, input logic ferr);
        vec_t v;
        v.rst = rst; v.pst = pst; v.fl = fl; v.npc = npc;
        v.wst = wst; v.ack = ack; v.err = err; v.dat = dat;
        v.cyc = cyc; v.stb = stb; v.addr = addr;
        v.bpc = bpc; v.binst = binst; v.ferr = ferr;
        return v;
    endfunction

    // Instruction memory contents seen by the random run; never zero for reachable pcs.
    function automatic logic [31:0] memf(input logic [31:0] pc);
        return pc ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        i_reset      = v.rst;
        i_pipe_stall = v.pst;
        i_pipe_flush = v.fl;
        i_new_pc     = v.npc;
        i_wb_stall   = v.wst;
        i_wb_ack     = v.ack;
        i_wb_err     = v.err;
        i_wb_data    = v.dat;
        @(posedge clk);
        #1;
        chk({nm, ".cyc"},   32'(o_wb_cyc),    32'(v.cyc));
        chk({nm, ".stb"},   32'(o_wb_stb),    32'(v.stb));
        chk({nm, ".addr"},  32'(o_wb_addr),   32'(v.addr));
        chk({nm, ".bpc"},   o_buf_pc,         v.bpc);
        chk({nm, ".binst"}, o_buf_inst,       v.binst);
        chk({nm, ".ferr"},  32'(o_fetch_err), 32'(v.ferr));
        $display("vec %s cyc=%b stb=%b addr=%h bpc=%h binst=%h ferr=%b",
                 nm, o_wb_cyc, o_wb_stb, o_wb_addr, o_buf_pc, o_buf_inst, o_fetch_err);
    endtask

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;

    logic [31:0] exp_req;
    logic [31:0] exp_del;
    logic [31:0] pend_pc;
    logic [31:0] prev_bpc;
    logic [31:0] prev_binst;
    logic        prev_pst;
    logic        pending;
    int          dly;
    int          ndel;

    initial begin
        i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; i_new_pc = 32'd0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'd0;

        //            rst pst fl npc           wst ack err dat            cyc stb addr          bpc           binst         ferr
        tbl[0]  = mkv(1, 0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 30'h0,        32'h0,        32'h0,        0);
        tbl[1]  = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 1, 30'h0,        32'h0,        32'h0,        0);
        tbl[2]  = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 0, 30'h0,        32'h0,        32'h0,        0);
        tbl[3]  = mkv(0, 0, 0, 32'h0,          0, 1, 0, 32'h0840_0000,  0, 0, 30'h0,        32'h0,        32'h0840_0000, 0);
        tbl[4]  = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 1, 30'h1,        32'h0,        32'h0,        0);
        tbl[5]  = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 0, 30'h1,        32'h0,        32'h0,        0);
        tbl[6]  = mkv(0, 0, 0, 32'h0,          0, 1, 0, 32'h1080_0004,  0, 0, 30'h1,        32'h4,        32'h1080_0004, 0);
        tbl[7]  = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 1, 30'h2,        32'h0,        32'h0,        0);
        tbl[8]  = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 0, 30'h2,        32'h0,        32'h0,        0);
        tbl[9]  = mkv(0, 0, 1, 32'h100,        0, 0, 0, 32'h0,          0, 0, 30'h2,        32'h0,        32'h0,        0);
        tbl[10] = mkv(0, 0, 0, 32'h0,          0, 1, 0, 32'hDEAD_BEEF,  1, 1, 30'h40,       32'h0,        32'h0,        0);
        tbl[11] = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 0, 30'h40,       32'h0,        32'h0,        0);
        tbl[12] = mkv(0, 0, 0, 32'h0,          0, 1, 0, 32'h1111_1111,  0, 0, 30'h40,       32'h100,      32'h1111_1111, 0);
        tbl[13] = mkv(0, 0, 1, 32'h102,        0, 0, 0, 32'h0,          0, 0, 30'h40,       32'h0,        32'h0,        1);
        tbl[14] = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 30'h40,       32'h0,        32'h0,        1);
        tbl[15] = mkv(0, 0, 1, 32'hFFFF_FFFC,  0, 1, 0, 32'h4444_4444,  0, 0, 30'h40,       32'h0,        32'h0,        0);
        tbl[16] = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 1, 30'h3FFF_FFFF, 32'h0,       32'h0,        0);
        tbl[17] = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 0, 30'h3FFF_FFFF, 32'h0,       32'h0,        0);
        tbl[18] = mkv(0, 0, 0, 32'h0,          0, 1, 0, 32'h2222_2222,  0, 0, 30'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h2222_2222, 0);
        tbl[19] = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 1, 30'h0,        32'h0,        32'h0,        0);
        tbl[20] = mkv(0, 0, 1, 32'h0,          0, 1, 0, 32'h5555_5555,  0, 0, 30'h0,        32'h0,        32'h0,        0);
        tbl[21] = mkv(0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          1, 1, 30'h0,        32'h0,        32'h0,        0);

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        // Ack while decode is stalled: word parks in the skid, buffer held, no new strobe.
        run_vec("stl_rst",  mkv(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 30'h0, 32'h0, 32'h0, 0));
        run_vec("stl_stb",  mkv(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 30'h0, 32'h0, 32'h0, 0));
        run_vec("stl_acc",  mkv(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 30'h0, 32'h0, 32'h0, 0));
        run_vec("stl_ackA", mkv(0, 0, 0, 0, 0, 1, 0, WA, 0, 0, 30'h0, 32'h0, WA, 0));
        run_vec("stl_idle", mkv(0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 30'h1, 32'h0, WA, 0));
        run_vec("stl_bus",  mkv(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 30'h1, 32'h0, WA, 0));
        run_vec("stl_ackB", mkv(0, 1, 0, 0, 0, 1, 0, WB, 0, 0, 30'h1, 32'h0, WA, 0));
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("stl_hold%0d", i), mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 30'h1, 32'h0, WA, 0));
        end
        run_vec("stl_rel",  mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 30'h1, 32'h4, WB, 0));
        run_vec("stl_next", mkv(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 30'h2, 32'h0, 32'h0, 0));

        // Bus stall holds the strobe and address steady.
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("wst%0d", i), mkv(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 30'h2, 32'h0, 32'h0, 0));
        end
        run_vec("wst_clr", mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 30'h2, 32'h0, 32'h0, 0));

        // Bus error on pc 8 (ack asserted alongside), then parked until a flush.
        run_vec("err_hit", mkv(0, 0, 0, 0, 0, 1, 1, 32'h7777_7777, 0, 0, 30'h2, 32'h0, 32'h0, 1));
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("err_park%0d", i), mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h2, 32'h0, 32'h0, 1));
        end
        run_vec("err_flush", mkv(0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 30'h2, 32'h0, 32'h0, 0));
        run_vec("err_resume", mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 30'h0, 32'h0, 32'h0, 0));

        // Reset mid-cycle, then a late ack that must not reach the buffer.
        run_vec("mrst_rst",  mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0, 32'h0, 32'h0, 0));
        run_vec("mrst_late", mkv(0, 0, 0, 0, 0, 1, 0, 32'h9999_9999, 1, 1, 30'h0, 32'h0, 32'h0, 0));
        run_vec("mrst_acc",  mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 30'h0, 32'h0, 32'h0, 0));
        run_vec("mrst_ack",  mkv(0, 0, 0, 0, 0, 1, 0, WA, 0, 0, 30'h0, 32'h0, WA, 0));

        // Randomized bus latency, bus stall and decode stall against an in-order stream model.
        run_vec("rnd_rst", mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0, 32'h0, 32'h0, 0));
        exp_req = 32'd0; exp_del = 32'd0; pend_pc = 32'd0;
        prev_bpc = 32'd0; prev_binst = 32'd0; prev_pst = 1'b0;
        pending = 1'b0; dly = 0; ndel = 0;
        for (int c = 0; c < 800; c++) begin
            if (prev_pst) begin
                chk("rnd_hold_pc",   o_buf_pc,   prev_bpc);
                chk("rnd_hold_inst", o_buf_inst, prev_binst);
            end else if (o_buf_inst != 32'd0) begin
                chk("rnd_del_pc",   o_buf_pc,   exp_del);
                chk("rnd_del_inst", o_buf_inst, memf(exp_del));
                $display("rnd deliver pc=%h inst=%h", o_buf_pc, o_buf_inst);
                exp_del = exp_del + 32'd4;
                ndel++;
            end else begin
                chk("rnd_bubble_pc", o_buf_pc, 32'd0);
            end
            if (pending) begin
                chk("rnd_cyc_held",      32'(o_wb_cyc), 32'd1);
                chk("rnd_no_second_stb", 32'(o_wb_stb), 32'd0);
            end
            chk("rnd_no_err", 32'(o_fetch_err), 32'd0);
            prev_bpc   = o_buf_pc;
            prev_binst = o_buf_inst;

            i_reset      = 1'b0;
            i_pipe_flush = 1'b0;
            i_new_pc     = 32'd0;
            i_wb_err     = 1'b0;
            i_wb_ack     = 1'b0;
            i_wb_data    = 32'd0;
            i_pipe_stall = ($urandom_range(0, 2) == 0);
            i_wb_stall   = ($urandom_range(0, 2) == 0);
            if (pending) begin
                if (dly == 0) begin
                    i_wb_ack  = 1'b1;
                    i_wb_data = memf(pend_pc);
                    pending   = 1'b0;
                end else begin
                    dly--;
                end
            end else if (o_wb_stb && !i_wb_stall) begin
                chk("rnd_req_addr", 32'(o_wb_addr), 32'(exp_req[31:2]));
                pend_pc = exp_req;
                exp_req = exp_req + 32'd4;
                pending = 1'b1;
                dly     = int'($urandom_range(0, 2));
            end
            prev_pst = i_pipe_stall;
            @(posedge clk);
            #1;
        end
        chk("rnd_deliveries_min", 32'(ndel >= 40), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
